soc_debug_control_mh: RTL and testbench

//  Multi-hart successor of the single-core SoC control block. An AXI4-Lite slave lets the Zynq PS

---
 rtl/soc_debug_control_mh.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_soc_debug_control_mh.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_debug_control_mh.sv
// soc_debug_control_mh: AXI4-Lite run control, PC/regfile access and
// bit-flip fault injection for an array of harts, with PC breakpoints.
module soc_debug_control_mh #(
    parameter int NUM_HARTS       = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int USED_ADDR_WIDTH = 12,
    parameter int STEP_WIDTH      = 16
) (
    input  logic                            CLK,
    input  logic                            RST,
    output logic [NUM_HARTS-1:0]            hart_stall,
    input  logic [NUM_HARTS*DATA_WIDTH-1:0] hart_pc_rdata,
    output logic [NUM_HARTS-1:0]            hart_pc_we,
    output logic [DATA_WIDTH-1:0]           pc_wdata,
    output logic [REG_ADDR_WIDTH-1:0]       rf_addr,
    input  logic [NUM_HARTS*DATA_WIDTH-1:0] rf_rdata,
    output logic [NUM_HARTS-1:0]            rf_we,
    output logic [DATA_WIDTH-1:0]           rf_wdata,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [31:0]                     S_AXI_AWADDR,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    input  logic [DATA_WIDTH-1:0]           S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]         S_AXI_WSTRB,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    output logic [1:0]                      S_AXI_BRESP,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    input  logic [31:0]                     S_AXI_ARADDR,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [DATA_WIDTH-1:0]           S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_RD_RESP,
        S_WR_ADDR, S_WR_DATA, S_WR_ISSUE, S_WR_RMW,
        S_WR_WAIT, S_WR_RESP
    } state_t;

    localparam logic [1:0] SUB_CTRL  = 2'd0;
    localparam logic [1:0] SUB_RF    = 2'd1;
    localparam logic [1:0] SUB_FAULT = 2'd2;
    localparam logic [1:0] SUB_BAD   = 2'd3;
    localparam logic [1:0] RESP_OK   = 2'b00;
    localparam logic [1:0] RESP_ERR  = 2'b10;

    state_t state, state_nx;

    logic [USED_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]      wdata;
    logic [DATA_WIDTH/8-1:0]    wstrb;
    logic [DATA_WIDTH-1:0]      rmw;
    logic [DATA_WIDTH-1:0]      rdata;
    logic [1:0]                 rresp;
    logic [1:0]                 bresp;

    logic [NUM_HARTS-1:0]       stall;
    logic [NUM_HARTS-1:0]       bp_hit;
    logic [NUM_HARTS-1:0]       bp_en;
    logic [NUM_HARTS-1:0]       bp_skip;
    logic [NUM_HARTS-1:0]       bp_match;
    logic [STEP_WIDTH-1:0]      steps [NUM_HARTS];
    logic [DATA_WIDTH-1:0]      bp_addr [NUM_HARTS];
    logic [DATA_WIDTH-1:0]      pc_arr [NUM_HARTS];

    logic [1:0]            sub;
    logic [2:0]            hart;
    logic [4:0]            word;
    logic                  wr_phase;
    logic                  hart_ok;
    logic                  err;
    logic                  ctrl_wr;
    logic [NUM_HARTS-1:0]  oh;
    logic [DATA_WIDTH-1:0] sel_pc;
    logic [DATA_WIDTH-1:0] sel_rf;
    logic [DATA_WIDTH-1:0] sel_status;
    logic [DATA_WIDTH-1:0] sel_bp;
    logic [DATA_WIDTH-1:0] sel_bpen;
    logic [DATA_WIDTH-1:0] rd_val;
    logic [STEP_WIDTH-1:0] step_n;
    logic                  unused_addr;

    assign unused_addr = ^{S_AXI_AWADDR[31:USED_ADDR_WIDTH],
                           S_AXI_ARADDR[31:USED_ADDR_WIDTH]};

    assign sub      = addr[11:10];
    assign hart     = addr[9:7];
    assign word     = addr[6:2];
    assign wr_phase = (state == S_WR_ISSUE) || (state == S_WR_RMW);
    assign hart_ok  = {29'b0, hart} < 32'(NUM_HARTS);
    assign step_n   = wdata[STEP_WIDTH-1:0];

    assign err = (sub == SUB_BAD) || !hart_ok || (addr[1:0] != 2'b00)
              || (wr_phase && (wstrb != '1))
              || ((sub == SUB_CTRL) && (word > 5'd6))
              || (wr_phase && (sub != SUB_CTRL) && (word == 5'd0));

    assign ctrl_wr = (state == S_WR_ISSUE) && !err && (sub == SUB_CTRL);

    always_comb begin
        oh         = '0;
        sel_pc     = '0;
        sel_rf     = '0;
        sel_status = '0;
        sel_bp     = '0;
        sel_bpen   = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if ({29'b0, hart} == 32'(h)) begin
                oh[h]      = 1'b1;
                sel_pc     = pc_arr[h];
                sel_rf     = rf_rdata[h*DATA_WIDTH +: DATA_WIDTH];
                sel_status = DATA_WIDTH'({16'(steps[h]), 14'b0,
                                          bp_hit[h], stall[h]});
                sel_bp     = bp_addr[h];
                sel_bpen   = DATA_WIDTH'(bp_en[h]);
            end
        end
    end

    always_comb begin
        for (int h = 0; h < NUM_HARTS; h++) begin
            pc_arr[h]   = hart_pc_rdata[h*DATA_WIDTH +: DATA_WIDTH];
            bp_match[h] = bp_en[h] && !stall[h] && !bp_skip[h]
                       && (pc_arr[h] == bp_addr[h]);
        end
    end

    always_comb begin
        rd_val = '0;
        if (!err) begin
            case (sub)
                SUB_CTRL: begin
                    case (word)
                        5'd0:    rd_val = sel_status;
                        5'd4:    rd_val = sel_pc;
                        5'd5:    rd_val = sel_bp;
                        5'd6:    rd_val = sel_bpen;
                        default: rd_val = '0;
                    endcase
                end
                default: rd_val = sel_rf;
            endcase
        end
    end

    // Core-side strobes exist only in the issue/RMW states.
    always_comb begin
        rf_addr    = '0;
        rf_we      = '0;
        rf_wdata   = '0;
        hart_pc_we = '0;
        pc_wdata   = '0;
        case (state)
            S_RD_ISSUE: begin
                if (!err && (sub != SUB_CTRL)) rf_addr = word;
            end
            S_WR_ISSUE: begin
                if (!err) begin
                    if (sub != SUB_CTRL) rf_addr = word;
                    if (sub == SUB_RF) begin
                        rf_we    = oh;
                        rf_wdata = wdata;
                    end
                    if ((sub == SUB_CTRL) && (word == 5'd4)) begin
                        hart_pc_we = oh;
                        pc_wdata   = wdata;
                    end
                end
            end
            S_WR_RMW: begin
                if (!err) begin
                    rf_addr  = word;
                    rf_we    = oh;
                    rf_wdata = rmw ^ wdata;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (S_AXI_ARVALID)      state_nx = S_RD_ISSUE;
                else if (S_AXI_AWVALID) state_nx = S_WR_ADDR;
            end
            S_RD_ISSUE: state_nx = S_RD_WAIT;
            S_RD_WAIT:  state_nx = S_RD_RESP;
            S_RD_RESP:  if (S_AXI_RREADY) state_nx = S_IDLE;
            S_WR_ADDR:  if (S_AXI_AWVALID) state_nx = S_WR_DATA;
            S_WR_DATA:  if (S_AXI_WVALID) state_nx = S_WR_ISSUE;
            S_WR_ISSUE: state_nx = (sub == SUB_FAULT) ? S_WR_RMW : S_WR_WAIT;
            S_WR_RMW:   state_nx = S_WR_WAIT;
            S_WR_WAIT:  state_nx = S_WR_RESP;
            S_WR_RESP:  if (S_AXI_BREADY) state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nx;
    end

    assign S_AXI_ARREADY = (state == S_IDLE);
    assign S_AXI_AWREADY = (state == S_WR_ADDR);
    assign S_AXI_WREADY  = (state == S_WR_DATA);
    assign S_AXI_RVALID  = (state == S_RD_RESP);
    assign S_AXI_BVALID  = (state == S_WR_RESP);
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = rresp;
    assign S_AXI_BRESP   = bresp;
    assign hart_stall    = stall;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr  <= '0;
            wdata <= '0;
            wstrb <= '0;
            rmw   <= '0;
            rdata <= '0;
            rresp <= RESP_OK;
            bresp <= RESP_OK;
        end else begin
            if ((state == S_IDLE) && S_AXI_ARVALID)
                addr <= S_AXI_ARADDR[USED_ADDR_WIDTH-1:0];
            if ((state == S_WR_ADDR) && S_AXI_AWVALID)
                addr <= S_AXI_AWADDR[USED_ADDR_WIDTH-1:0];
            if ((state == S_WR_DATA) && S_AXI_WVALID) begin
                wdata <= S_AXI_WDATA;
                wstrb <= S_AXI_WSTRB;
            end
            if (state == S_RD_ISSUE) begin
                rdata <= rd_val;
                rresp <= err ? RESP_ERR : RESP_OK;
            end
            if (state == S_WR_ISSUE) begin
                rmw   <= sel_rf;
                bresp <= err ? RESP_ERR : RESP_OK;
            end
        end
    end

    // Autonomous run control first; a bus command to the hart overrides it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall   <= '1;
            bp_hit  <= '0;
            bp_en   <= '0;
            bp_skip <= '0;
            for (int h = 0; h < NUM_HARTS; h++) begin
                steps[h]   <= '0;
                bp_addr[h] <= '0;
            end
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (bp_skip[h] && (pc_arr[h] != bp_addr[h]))
                    bp_skip[h] <= 1'b0;
                if (bp_match[h]) begin
                    stall[h]  <= 1'b1;
                    bp_hit[h] <= 1'b1;
                    steps[h]  <= '0;
                end else if (!stall[h] && (steps[h] != '0)) begin
                    steps[h] <= steps[h] - 1'b1;
                    if (steps[h] == STEP_WIDTH'(1)) stall[h] <= 1'b1;
                end
                if (ctrl_wr && oh[h]) begin
                    case (word)
                        5'd1: begin
                            stall[h]   <= 1'b0;
                            steps[h]   <= '0;
                            bp_hit[h]  <= 1'b0;
                            bp_skip[h] <= (pc_arr[h] == bp_addr[h]);
                        end
                        5'd2: begin
                            stall[h] <= 1'b1;
                            steps[h] <= '0;
                        end
                        5'd3: begin
                            stall[h]   <= 1'b0;
                            steps[h]   <= (step_n == '0) ? STEP_WIDTH'(1) : step_n;
                            bp_hit[h]  <= 1'b0;
                            bp_skip[h] <= (pc_arr[h] == bp_addr[h]);
                        end
                        5'd5: bp_addr[h] <= wdata;
                        5'd6: bp_en[h]   <= wdata[0];
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_soc_debug_control_mh.sv
// Testbench for soc_debug_control_mh: vector table of AXI accesses plus
// sequences for stepping, breakpoints, AR/AW collision and reset abort.
module tb_soc_debug_control_mh;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  hart_stall;
    logic [63:0] hart_pc_rdata;
    logic [1:0]  hart_pc_we;
    logic [31:0] pc_wdata;
    logic [4:0]  rf_addr;
    logic [63:0] rf_rdata;
    logic [1:0]  rf_we;
    logic [31:0] rf_wdata;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_AWADDR = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_ARADDR = '0;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;

    soc_debug_control_mh dut (
        .CLK(CLK), .RST(RST),
        .hart_stall(hart_stall), .hart_pc_rdata(hart_pc_rdata),
        .hart_pc_we(hart_pc_we), .pc_wdata(pc_wdata),
        .rf_addr(rf_addr), .rf_rdata(rf_rdata),
        .rf_we(rf_we), .rf_wdata(rf_wdata),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_AWADDR(S_AXI_AWADDR),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_BRESP(S_AXI_BRESP),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP)
    );

    always #5 CLK = ~CLK;

    // Simple hart models: regfile with async read, PC advancing by 4 per run cycle.
    logic [31:0] rf_mem [2][32] = '{default: '0};
    logic [31:0] pc [2] = '{default: '0};

    assign rf_rdata      = {rf_mem[1][rf_addr], rf_mem[0][rf_addr]};
    assign hart_pc_rdata = {pc[1], pc[0]};

    always @(posedge CLK) begin
        for (int h = 0; h < 2; h++) begin
            if (rf_we[h]) rf_mem[h][rf_addr] <= rf_wdata;
            if (hart_pc_we[h])    pc[h] <= pc_wdata;
            else if (!hart_stall[h]) pc[h] <= pc[h] + 32'd4;
        end
    end

    int low_cnt = 0;
    always @(posedge CLK) if (!hart_stall[0]) low_cnt++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                            output logic [1:0] r, output int lat);
        int n;
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b1;
        n = 0;
        while (!S_AXI_ARREADY && n < 20) begin tick(); n++; end
        tick();
        S_AXI_ARVALID = 1'b0;
        lat = 1;
        while (!S_AXI_RVALID && lat < 20) begin tick(); lat++; end
        if (!S_AXI_RVALID) check("rd_timeout", 32'(S_AXI_RVALID), 32'd1);
        d = S_AXI_RDATA;
        r = S_AXI_RRESP;
        tick();
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] r,
                             output int lat);
        int n;
        S_AXI_AWADDR  = a;
        S_AXI_AWVALID = 1'b1;
        n = 0;
        while (!S_AXI_AWREADY && n < 20) begin tick(); n++; end
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = d;
        S_AXI_WSTRB   = s;
        S_AXI_WVALID  = 1'b1;
        n = 0;
        while (!S_AXI_WREADY && n < 20) begin tick(); n++; end
        tick();
        S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b1;
        lat = 1;
        while (!S_AXI_BVALID && lat < 20) begin tick(); lat++; end
        if (!S_AXI_BVALID) check("wr_timeout", 32'(S_AXI_BVALID), 32'd1);
        r = S_AXI_BRESP;
        tick();
        S_AXI_BREADY = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        int          exp_lat;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] ed, input logic [1:0] er,
                       input int el);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.strb = s;
        v.exp_d = ed; v.exp_r = er; v.exp_lat = el;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        int          base;
        int          n;
        logic        seen;

        add(1, 32'h414, 32'hA5A5A5A5, 4'hF, 0, 2'b00, 3);
        add(0, 32'h414, 0, 4'hF, 32'hA5A5A5A5, 2'b00, 3);
        add(1, 32'h814, 32'h0000000F, 4'hF, 0, 2'b00, 4);
        add(0, 32'h414, 0, 4'hF, 32'hA5A5A5AA, 2'b00, 3);
        add(0, 32'h814, 0, 4'hF, 32'hA5A5A5AA, 2'b00, 3);
        add(1, 32'h494, 32'h12345678, 4'hF, 0, 2'b00, 3);
        add(0, 32'h494, 0, 4'hF, 32'h12345678, 2'b00, 3);
        add(0, 32'h414, 0, 4'hF, 32'hA5A5A5AA, 2'b00, 3);
        add(0, 32'h400, 0, 4'hF, 32'h0, 2'b00, 3);
        add(1, 32'h400, 32'h1, 4'hF, 0, 2'b10, 3);
        add(1, 32'h800, 32'h1, 4'hF, 0, 2'b10, 4);
        add(1, 32'h418, 32'hFFFF, 4'h3, 0, 2'b10, 3);
        add(0, 32'h418, 0, 4'hF, 32'h0, 2'b00, 3);
        add(1, 32'h180, 32'h1, 4'hF, 0, 2'b10, 3);
        add(0, 32'h180, 0, 4'hF, 32'h0, 2'b10, 3);
        add(0, 32'hC00, 0, 4'hF, 32'h0, 2'b10, 3);
        add(1, 32'hC00, 32'h1, 4'hF, 0, 2'b10, 3);
        add(0, 32'h402, 0, 4'hF, 32'h0, 2'b10, 3);
        add(0, 32'h01C, 0, 4'hF, 32'h0, 2'b10, 3);
        add(0, 32'h004, 0, 4'hF, 32'h0, 2'b00, 3);
        add(1, 32'h014, 32'h40, 4'hF, 0, 2'b00, 3);
        add(0, 32'h014, 0, 4'hF, 32'h40, 2'b00, 3);
        add(1, 32'h018, 32'h1, 4'hF, 0, 2'b00, 3);
        add(0, 32'h018, 0, 4'hF, 32'h1, 2'b00, 3);
        add(1, 32'h018, 32'h0, 4'hF, 0, 2'b00, 3);
        add(0, 32'h000, 0, 4'hF, 32'h1, 2'b00, 3);

        repeat (3) @(posedge CLK);
        #1;
        check("rst_stall", 32'(hart_stall), 32'h3);
        check("rst_arready", 32'(S_AXI_ARREADY), 32'h1);
        check("rst_hs", 32'({S_AXI_AWREADY, S_AXI_WREADY,
                             S_AXI_RVALID, S_AXI_BVALID}), 32'h0);
        check("rst_core", 32'({rf_we, hart_pc_we, rf_addr}), 32'h0);
        check("rst_data", pc_wdata | rf_wdata | S_AXI_RDATA, 32'h0);
        RST = 1'b0;
        tick();

        axi_read(32'h080, d, r, lat);
        check("rst_status_h1", d, 32'h1);
        check("rst_status_resp", 32'(r), 32'h0);
        check("rd_latency", 32'(lat), 32'd3);

        foreach (tbl[i]) begin
            if (tbl[i].wr) begin
                axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, r, lat);
            end else begin
                axi_read(tbl[i].addr, d, r, lat);
                check($sformatf("vec%0d_data", i), d, tbl[i].exp_d);
            end
            check($sformatf("vec%0d_resp", i), 32'(r), 32'(tbl[i].exp_r));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
        end

        // Step hart0 by 5 cycles.
        base = low_cnt;
        axi_write(32'h00C, 32'd5, 4'hF, r, lat);
        check("step5_running", 32'(hart_stall[0]), 32'h0);
        n = 0;
        while (!hart_stall[0] && n < 50) begin tick(); n++; end
        check("step5_cycles", 32'(low_cnt - base), 32'd5);
        axi_read(32'h000, d, r, lat);
        check("step5_status", d, 32'h1);

        // Mid-run status: 100 loaded, 3 cycles elapsed before the read issues.
        axi_write(32'h00C, 32'd100, 4'hF, r, lat);
        axi_read(32'h000, d, r, lat);
        check("step100_status", d, 32'h0061_0000);
        axi_write(32'h008, 32'd0, 4'hF, r, lat);
        check("stop_stall", 32'(hart_stall[0]), 32'h1);
        axi_read(32'h000, d, r, lat);
        check("stop_status", d, 32'h1);

        // Breakpoint on hart1.
        axi_write(32'h090, 32'hF0, 4'hF, r, lat);
        axi_read(32'h090, d, r, lat);
        check("h1_pc_write", d, 32'hF0);
        axi_write(32'h094, 32'h100, 4'hF, r, lat);
        axi_write(32'h098, 32'h1, 4'hF, r, lat);
        axi_write(32'h084, 32'h0, 4'hF, r, lat);
        n = 0;
        while (!hart_stall[1] && n < 50) begin tick(); n++; end
        check("bp_stall", 32'(hart_stall[1]), 32'h1);
        axi_read(32'h080, d, r, lat);
        check("bp_status", d, 32'h3);
        axi_read(32'h090, d, r, lat);
        check("bp_pc", d, 32'h104);

        // Step while sitting on the breakpoint: runs all 3 cycles.
        axi_write(32'h090, 32'h100, 4'hF, r, lat);
        axi_write(32'h08C, 32'd3, 4'hF, r, lat);
        repeat (10) tick();
        axi_read(32'h080, d, r, lat);
        check("bp_rearm_status", d, 32'h1);
        axi_read(32'h090, d, r, lat);
        check("bp_rearm_pc", d, 32'h10C);

        axi_write(32'h084, 32'h0, 4'hF, r, lat);
        check("h1_start", 32'(hart_stall), 32'h1);

        // AR and AW together: read goes first.
        S_AXI_ARADDR  = 32'h494;
        S_AXI_ARVALID = 1'b1;
        S_AXI_AWADDR  = 32'h494;
        S_AXI_AWVALID = 1'b1;
        S_AXI_RREADY  = 1'b1;
        tick();
        S_AXI_ARVALID = 1'b0;
        check("collide_awready", 32'(S_AXI_AWREADY), 32'h0);
        lat = 1;
        while (!S_AXI_RVALID && lat < 20) begin tick(); lat++; end
        check("collide_rd_lat", 32'(lat), 32'd3);
        check("collide_rd_data", S_AXI_RDATA, 32'h12345678);
        tick();
        S_AXI_RREADY = 1'b0;
        axi_write(32'h494, 32'hDEADBEEF, 4'hF, r, lat);
        check("collide_wr_resp", 32'(r), 32'h0);
        axi_read(32'h494, d, r, lat);
        check("collide_wr_data", d, 32'hDEADBEEF);

        // Reset while a regfile write sits in WR_ISSUE.
        S_AXI_AWADDR  = 32'h418;
        S_AXI_AWVALID = 1'b1;
        tick();
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = 32'h55;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_WVALID  = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        check("issue_we", 32'(rf_we), 32'h1);
        RST = 1'b1;
        #1;
        check("abort_we", 32'(rf_we), 32'h0);
        check("abort_stall", 32'(hart_stall), 32'h3);
        check("abort_arready", 32'(S_AXI_ARREADY), 32'h1);
        tick();
        tick();
        RST = 1'b0;
        S_AXI_BREADY = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (S_AXI_BVALID) seen = 1'b1;
        end
        S_AXI_BREADY = 1'b0;
        check("abort_no_bvalid", 32'(seen), 32'h0);
        axi_read(32'h418, d, r, lat);
        check("abort_no_write", d, 32'h0);
        axi_read(32'h098, d, r, lat);
        check("abort_bp_en", d, 32'h0);
        axi_read(32'h080, d, r, lat);
        check("abort_status_h1", d, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
